hash_msg_feeder: RTL

Upstream stage of the DES-based hash core (`fullHashDES`). It accepts a message from the host as a byte stream with a valid/ready handshake and buffers it in a small FIFO. It then drives the core's `C_in` / `M_valid` / `M` inputs, one byte per cycle. After the last byte it waits for `hash_ready`, captures `digest_final` into a result register and reports completion or timeout.

---
 rtl/hash_msg_feeder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hash_msg_feeder.sv
`default_nettype none
// ============================================================================
// Module   : hash_msg_feeder
// Purpose  : Buffers a host byte stream and feeds it to the DES hash core,
//            then captures the digest or reports a timeout.
// Revision : 1.0  initial release
// ============================================================================
module hash_msg_feeder #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [63:0] hash_C,
    output logic        hash_M_valid,
    output logic [7:0]  hash_M,
    input  logic        hash_ready,
    input  logic [31:0] hash_digest,
    output logic [31:0] digest,
    output logic        digest_valid,
    output logic        timeout,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    logic [1:0]    state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [63:0]   acc_cnt;
    logic [63:0]   sent_cnt;
    logic [WW-1:0] wait_cnt;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign in_ready = (state == ST_STREAM) && !fifo_full && (acc_cnt < hash_C);
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_STREAM) && !fifo_empty;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            acc_cnt      <= '0;
            sent_cnt     <= '0;
            wait_cnt     <= '0;
            hash_C       <= '0;
            hash_M       <= '0;
            hash_M_valid <= 1'b0;
            digest       <= '0;
            digest_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            timeout      <= 1'b0;

            // push is only possible in STREAM, since in_ready gates it
            if (push) begin
                wr_ptr  <= wr_ptr + 1'b1;
                acc_cnt <= acc_cnt + 64'd1;
            end

            case (state)
                ST_IDLE: begin
                    hash_M_valid <= 1'b0;
                    if (start && (len != 64'd0)) begin
                        hash_C   <= len;
                        acc_cnt  <= '0;
                        sent_cnt <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        state    <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    if (pop) begin
                        hash_M       <= mem[rd_ptr[AW-1:0]];
                        hash_M_valid <= 1'b1;
                        rd_ptr       <= rd_ptr + 1'b1;
                        sent_cnt     <= sent_cnt + 64'd1;
                        if ((sent_cnt + 64'd1) == hash_C) begin
                            wait_cnt <= '0;
                            state    <= ST_WAIT;
                        end
                    end else begin
                        hash_M_valid <= 1'b0;
                    end
                end

                ST_WAIT: begin
                    hash_M_valid <= 1'b0;
                    if (hash_ready) begin
                        digest       <= hash_digest;
                        digest_valid <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                default: begin
                    hash_M_valid <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
